// File: rtl/in128_out1536_pack.sv
// Packs a 128-bit AXI-Stream into 1536-bit words of 12 lanes with a per-lane tlast bitmap.
// Double-buffered: an assembly register feeds an output register toward inter_switch.
module in128_out1536_pack #(
    parameter int DWIDTH_IN = 128,
    parameter int LANES     = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DWIDTH_IN-1:0]         s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [DWIDTH_IN*LANES-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [LANES-1:0]             m_axis_tlast
);

    localparam int DWIDTH_OUT = DWIDTH_IN * LANES;
    localparam int PTR_W      = $clog2(LANES);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    logic [PTR_W-1:0]      r_lane_ptr;
    logic [DWIDTH_OUT-1:0] r_asm_buf;
    logic [LANES-1:0]      r_asm_tlast;
    logic                  r_asm_full;
    logic [DWIDTH_OUT-1:0] r_out_buf;
    logic [LANES-1:0]      r_out_tlast;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_slot_free;
    logic                  w_complete;
    logic [DWIDTH_OUT-1:0] w_merged;
    logic [LANES-1:0]      w_merged_tlast;

    assign s_axis_tready = !r_asm_full;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_buf;
    assign m_axis_tlast  = r_out_tlast;

    assign w_accept    = s_axis_tvalid && !r_asm_full;
    assign w_slot_free = !r_out_valid || m_axis_tready;
    assign w_complete  = w_accept && ((r_lane_ptr == LAST_LANE) || s_axis_tlast);

    // Assembly word with the incoming beat dropped into the current lane.
    always_comb begin
        w_merged       = r_asm_buf;
        w_merged_tlast = r_asm_tlast;
        for (int k = 0; k < LANES; k++) begin
            if (r_lane_ptr == PTR_W'(k)) begin
                w_merged[k*DWIDTH_IN +: DWIDTH_IN] = s_axis_tdata;
                w_merged_tlast[k]                  = s_axis_tlast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_ptr  <= '0;
            r_asm_buf   <= '0;
            r_asm_tlast <= '0;
            r_asm_full  <= 1'b0;
            r_out_buf   <= '0;
            r_out_tlast <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
            if (r_asm_full) begin
                if (w_slot_free) begin
                    r_out_buf   <= r_asm_buf;
                    r_out_tlast <= r_asm_tlast;
                    r_out_valid <= 1'b1;
                    r_asm_full  <= 1'b0;
                    r_asm_buf   <= '0;
                    r_asm_tlast <= '0;
                    r_lane_ptr  <= '0;
                end
            end else if (w_complete) begin
                if (w_slot_free) begin
                    r_out_buf   <= w_merged;
                    r_out_tlast <= w_merged_tlast;
                    r_out_valid <= 1'b1;
                    r_asm_buf   <= '0;
                    r_asm_tlast <= '0;
                    r_lane_ptr  <= '0;
                end else begin
                    // Park the finished word; input stalls until the out slot frees.
                    r_asm_buf   <= w_merged;
                    r_asm_tlast <= w_merged_tlast;
                    r_asm_full  <= 1'b1;
                end
            end else if (w_accept) begin
                r_asm_buf  <= w_merged;
                r_lane_ptr <= r_lane_ptr + 1'b1;
            end
        end
    end

    a_out_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_out_valid && !m_axis_tready) |=>
            (r_out_valid && $stable(r_out_buf) && $stable(r_out_tlast))
    );

endmodule

// File: tb/tb_in128_out1536_pack.sv
// Randomized and directed bench for in128_out1536_pack with a queue-based word model.
// Expected words are built from accepted beats: up to 12 per word, cut early at tlast.
module tb_in128_out1536_pack;

    localparam int W  = 128;
    localparam int L  = 12;
    localparam int WO = W * L;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [WO-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [L-1:0]  m_axis_tlast;

    int rdy_mode;
    bit rnd_bit;
    assign m_axis_tready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 0);

    in128_out1536_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom % 2);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_words_out = 0;

    typedef struct {
        logic [WO-1:0] d;
        logic [L-1:0]  t;
    } word_t;

    logic [W-1:0] cur_q[$];
    word_t        exp_q[$];
    word_t        mw;
    word_t        ew;
    bit           prev_stall;
    logic [WO-1:0] prev_d;
    logic [L-1:0]  prev_t;

    function automatic logic [W-1:0] lane(input logic [WO-1:0] w, input int k);
        return w[k*W +: W];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < L; k++) begin
                if (lane(act, k) !== lane(exp, k)) begin
                    $display("FAIL %s lane %0d: got %h want %h", name, k, lane(act, k), lane(exp, k));
                    break;
                end
            end
        end
    endtask

    // Scoreboard: every output handshake is checked against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_q.delete();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", W'(m_axis_tvalid), W'(1));
                chk_word("hold_data", m_axis_tdata, prev_d);
                chk("hold_tlast", W'(m_axis_tlast), W'(prev_t));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_words_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got word %0d want none", n_words_out);
                end else begin
                    ew = exp_q.pop_front();
                    chk_word("word_data", m_axis_tdata, ew.d);
                    chk("word_tlast", W'(m_axis_tlast), W'(ew.t));
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                cur_q.push_back(s_axis_tdata);
                if (s_axis_tlast || cur_q.size() == L) begin
                    mw.d = '0;
                    foreach (cur_q[i]) mw.d[i*W +: W] = cur_q[i];
                    mw.t = s_axis_tlast ? (L'(1) << (cur_q.size() - 1)) : '0;
                    exp_q.push_back(mw);
                    cur_q.delete();
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_t     = m_axis_tlast;
        end
    end

    task automatic send(input logic [W-1:0] d, input bit last);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 5000) begin
                $display("FAIL send_timeout: got tready low %0d cycles want accept", n);
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "stuck");
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int words_before;

    initial begin
        rst_n         = 1'b1;
        rdy_mode      = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", W'(m_axis_tvalid), W'(0));
        chk("rst_tready", W'(s_axis_tready), W'(1));
        chk("rst_tlast", W'(m_axis_tlast), W'(0));
        chk_word("rst_tdata", m_axis_tdata, '0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // 24 beats, full throughput
        for (int i = 0; i < 24; i++) begin
            send(W'(i), 1'b0);
            chk("t1_tready", W'(s_axis_tready), W'(1));
            if (i == 10 || i == 12) chk("t1_novalid", W'(m_axis_tvalid), W'(0));
            if (i == 11 || i == 23) begin
                chk("t1_valid", W'(m_axis_tvalid), W'(1));
                chk("t1_tlast", W'(m_axis_tlast), W'(0));
                chk("t1_lane0", lane(m_axis_tdata, 0), W'(i - 11));
                chk("t1_lane5", lane(m_axis_tdata, 5), W'(i - 6));
                chk("t1_lane11", lane(m_axis_tdata, 11), W'(i));
            end
        end
        idle(2);

        // short packet then full word
        for (int i = 0; i < 5; i++) send(W'(200 + i), i == 4);
        chk("t2_valid", W'(m_axis_tvalid), W'(1));
        chk("t2_tlast", W'(m_axis_tlast), W'(12'h010));
        chk("t2_lane4", lane(m_axis_tdata, 4), W'(204));
        chk("t2_lane5", lane(m_axis_tdata, 5), W'(0));
        chk("t2_lane11", lane(m_axis_tdata, 11), W'(0));
        for (int i = 0; i < 12; i++) send(W'(300 + i), 1'b0);
        chk("t2b_lane0", lane(m_axis_tdata, 0), W'(300));
        chk("t2b_tlast", W'(m_axis_tlast), W'(0));

        // tlast on 12th beat
        for (int i = 0; i < 12; i++) send(W'(400 + i), i == 11);
        chk("t3_tlast", W'(m_axis_tlast), W'(12'h800));
        chk("t3_lane11", lane(m_axis_tdata, 11), W'(411));
        idle(2);

        // backpressure: two words held
        rdy_mode = 1;
        for (int i = 0; i < 24; i++) send(W'(500 + i), 1'b0);
        chk("t4_tready_low", W'(s_axis_tready), W'(0));
        chk("t4_valid", W'(m_axis_tvalid), W'(1));
        chk("t4_w1_lane0", lane(m_axis_tdata, 0), W'(500));
        idle(5);
        chk("t4_still_low", W'(s_axis_tready), W'(0));
        chk("t4_hold_lane11", lane(m_axis_tdata, 11), W'(511));
        fork
            begin
                for (int i = 24; i < 30; i++) send(W'(500 + i), i == 29);
            end
            begin
                rdy_mode = 0;
                idle(1);
                chk("t4_w2_lane0", lane(m_axis_tdata, 0), W'(512));
                chk("t4_w2_valid", W'(m_axis_tvalid), W'(1));
                chk("t4_tready_back", W'(s_axis_tready), W'(1));
            end
        join
        chk("t4_tail_tlast", W'(m_axis_tlast), W'(12'h020));
        chk("t4_tail_lane5", lane(m_axis_tdata, 5), W'(529));
        idle(3);

        // reset mid-word
        for (int i = 0; i < 7; i++) send(W'(600 + i), 1'b0);
        idle(2);
        words_before = n_words_out;
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", W'(m_axis_tvalid), W'(0));
        chk("t6_tready", W'(s_axis_tready), W'(1));
        chk("t6_tlast", W'(m_axis_tlast), W'(0));
        chk_word("t6_tdata", m_axis_tdata, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(W'(700 + i), 1'b0);
            if (i == 10) chk("t6_no_word", W'(n_words_out), W'(words_before));
        end
        chk("t6_valid", W'(m_axis_tvalid), W'(1));
        chk("t6_lane0", lane(m_axis_tdata, 0), W'(700));
        chk("t6_lane7", lane(m_axis_tdata, 7), W'(707));
        idle(2);

        // random packets with random backpressure
        rdy_mode = 2;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                if ($urandom % 2 == 0) idle(1);
                send({$urandom, $urandom, $urandom, $urandom}, b == len - 1);
            end
        end
        rdy_mode = 0;
        idle(10);
        chk("drain_exp", W'(exp_q.size()), W'(0));
        chk("drain_partial", W'(cur_q.size()), W'(0));
        chk("drain_valid", W'(m_axis_tvalid), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
